load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 59 +++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 size codes and lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Loads and stores share the size field; the unsigned codes exist only for loads.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
    } lsu_req_t;

    function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
        case (funct3)
            LB, LH, LW: return 1'b1;
            LBU, LHU:   return !we;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic funct3_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            LH, LHU: return !addr_lo[0];
            LW:      return addr_lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            SB, LBU: return 4'b0001 << addr_lo;
            SH, LHU: return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3)
            SB:      return {4{wdata[7:0]}};
            SH:      return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
import lsu_pkg::*;

module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (funct3)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LBU:     load_data = {24'h000000, byte_sel};
            LHU:     load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding bus transaction, pipeline stall
// while it is in flight, and a fault pulse for misaligned or illegal accesses.
import lsu_pkg::*;

module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_write_m_i,
    input  logic        mem_read_m_i,
    input  logic [2:0]  funct3_m_i,
    input  logic [31:0] addr_m_i,
    input  logic [31:0] wdata_m_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] load_q;
    logic [31:0] aligned_data;

    logic access;
    logic access_ok;
    logic accept;
    logic capture_load;

    assign access    = mem_write_m_i | mem_read_m_i;
    assign access_ok = funct3_legal(funct3_m_i, mem_write_m_i)
                     & funct3_aligned(funct3_m_i, addr_m_i[1:0]);

    lsu_load_align u_load_align (
        .rdata     (bus_rdata_i),
        .funct3    (req_q.funct3),
        .addr_lo   (req_q.addr[1:0]),
        .load_data (aligned_data)
    );

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture_load = 1'b0;
        stall_o      = 1'b0;
        fault_o      = 1'b0;
        bus_req_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (access_ok) begin
                        accept  = 1'b1;
                        stall_o = 1'b1;
                        state_d = REQ;
                    end else begin
                        fault_o = 1'b1;
                    end
                end
            end
            REQ: begin
                bus_req_o = 1'b1;
                stall_o   = 1'b1;
                if (bus_gnt_i) state_d = RSP;
            end
            RSP: begin
                stall_o = 1'b1;
                if (bus_rvalid_i) begin
                    capture_load = !req_q.we;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The IDLE-state outputs depend on live inputs, so reset must mask them too.
        if (rst_i) begin
            accept  = 1'b0;
            stall_o = 1'b0;
            fault_o = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the captured request and load result are reset so the bus fields read zero after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q.we     <= mem_write_m_i;
                req_q.addr   <= addr_m_i;
                req_q.funct3 <= funct3_m_i;
                be_q         <= byte_enable(funct3_m_i, addr_m_i[1:0]);
                wdata_q      <= mem_write_m_i ? store_data(funct3_m_i, wdata_m_i) : 32'h0;
            end
            if (capture_load) load_q <= aligned_data;
        end
    end

    assign bus_we_o    = req_q.we;
    assign bus_addr_o  = {req_q.addr[31:2], 2'b00};
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign load_data_o = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with an arithmetic reference model.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_write_m_i, mem_read_m_i;
    logic [2:0]  funct3_m_i;
    logic [31:0] addr_m_i, wdata_m_i;
    logic        stall_o, fault_o, bus_req_o, bus_we_o;
    logic [31:0] load_data_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    load_store_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_write_m_i(mem_write_m_i), .mem_read_m_i(mem_read_m_i),
        .funct3_m_i(funct3_m_i), .addr_m_i(addr_m_i), .wdata_m_i(wdata_m_i),
        .stall_o(stall_o), .load_data_o(load_data_o), .fault_o(fault_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        is_fault;
        bit        we;
        bit        is_load;
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
        bit [31:0] load_data;
        int        stall_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: access size in bytes, offset in word, shifts and masks.
    function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                   input bit [31:0] wdata, input bit [31:0] rdata,
                                   input int gnt_dly, input int rv_dly);
        exp_t e;
        int size, off;
        bit illegal;
        bit [31:0] mask, v;
        e.is_fault = 0; e.we = 0; e.is_load = 0; e.addr = 0; e.be = 0;
        e.wdata = 0; e.load_data = 0; e.stall_cycles = 0;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off     = int'(addr % 4);
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
        if (illegal || (addr % size) != 0) begin
            e.is_fault = 1;
            return e;
        end
        e.we           = we;
        e.addr         = addr & 32'hFFFF_FFFC;
        e.stall_cycles = gnt_dly + rv_dly + 3;
        if (we) begin
            e.be    = 4'(((1 << size) - 1) << off);
            e.wdata = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
                      (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
        end else begin
            e.is_load = 1;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
            v    = (rdata >> (8 * off)) & mask;
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
            e.load_data = v;
        end
        return e;
    endfunction

    task automatic idle_inputs();
        mem_write_m_i = 0; mem_read_m_i = 0; funct3_m_i = 0; addr_m_i = 0; wdata_m_i = 0;
    endtask

    // Drives one M-stage access and plays the bus slave with the given delays.
    task automatic do_access(input bit we, input bit rd, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wdata, input bit [31:0] rdata,
                             input int gnt_dly, input int rv_dly, input bit spurious);
        exp_t e;
        e = model(we, f3, addr, wdata, rdata, gnt_dly, rv_dly);
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        mem_write_m_i = we; mem_read_m_i = rd; funct3_m_i = f3; addr_m_i = addr; wdata_m_i = wdata;
        @(posedge clk_i); #1;
        if (e.is_fault) begin
            idle_inputs();
            return;
        end
        for (int k = 0; k < gnt_dly; k++) begin
            bus_rvalid_i = spurious;
            bus_rdata_i  = $urandom;
            @(posedge clk_i); #1;
        end
        bus_rvalid_i = 0;
        bus_gnt_i    = 1;
        @(posedge clk_i); #1;
        bus_gnt_i = 0;
        for (int k = 0; k < rv_dly; k++) begin
            @(posedge clk_i); #1;
        end
        bus_rvalid_i = 1;
        bus_rdata_i  = rdata;
        @(posedge clk_i); #1;
        bus_rvalid_i = 0;
        bus_rdata_i  = $urandom;
        idle_inputs();
    endtask

    // Starts a load, resets it in REQ or RSP, then sends a stray response.
    task automatic reset_mid(input bit in_req);
        exp_t e;
        e = model(0, 3'b010, 32'h300, 0, 32'hA5A5_A5A5, 0, 0);
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        mem_read_m_i = 1; funct3_m_i = 3'b010; addr_m_i = 32'h300;
        @(posedge clk_i); #1;
        if (!in_req) begin
            bus_gnt_i = 1;
            @(posedge clk_i); #1;
            bus_gnt_i = 0;
        end
        rst_i = 1;
        idle_inputs();
        @(posedge clk_i); #1;
        rst_i        = 0;
        bus_gnt_i    = 1;
        bus_rvalid_i = 1;
        bus_rdata_i  = 32'hA5A5_A5A5;
        @(posedge clk_i); #1;
        bus_gnt_i    = 0;
        bus_rvalid_i = 0;
        @(posedge clk_i); #1;
    endtask

    // Monitor: compares DUT behaviour against the front of the scoreboard.
    bit          prev_stall = 0;
    int          stall_cnt  = 0;
    logic [31:0] hold_data  = 0;

    always @(negedge clk_i) begin
        exp_t e;
        bit   done;
        if (rst_i) begin
            check("rst_stall", 32'(stall_o), 0);
            check("rst_bus_req", 32'(bus_req_o), 0);
            check("rst_fault", 32'(fault_o), 0);
            check("rst_load_data", load_data_o, 0);
            check("rst_bus_addr", bus_addr_o, 0);
            check("rst_bus_wdata", bus_wdata_o, 0);
            check("rst_bus_be", 32'(bus_be_o), 0);
            exp_q.delete();
            prev_stall = 0;
            stall_cnt  = 0;
            hold_data  = 0;
        end else begin
            done = prev_stall && !stall_o;
            if (fault_o) begin
                if (exp_q.size() == 0 || !exp_q[0].is_fault) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fault: got fault_o=1 expected 0 at %0t", $time);
                end else begin
                    check("fault_stall", 32'(stall_o), 0);
                    check("fault_bus_req", 32'(bus_req_o), 0);
                    void'(exp_q.pop_front());
                end
            end
            if (bus_req_o) begin
                if (exp_q.size() == 0 || exp_q[0].is_fault) begin
                    checks++; failures++;
                    $display("FAIL unexpected_bus_req: got bus_req_o=1 expected 0 at %0t", $time);
                end else begin
                    check("bus_we", 32'(bus_we_o), 32'(exp_q[0].we));
                    check("bus_addr", bus_addr_o, exp_q[0].addr);
                    if (exp_q[0].we) begin
                        check("bus_be", 32'(bus_be_o), 32'(exp_q[0].be));
                        check("bus_wdata", bus_wdata_o, exp_q[0].wdata);
                    end
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || exp_q[0].is_fault) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got completion expected none at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stall_cycles", 32'(stall_cnt), 32'(e.stall_cycles));
                    if (e.is_load) hold_data = e.load_data;
                    check("load_data", load_data_o, hold_data);
                end
            end else if (!stall_o) begin
                check("load_hold", load_data_o, hold_data);
            end
            stall_cnt  = stall_o ? stall_cnt + 1 : 0;
            prev_stall = stall_o;
        end
    end

    initial begin
        bit we, rd;
        rst_i = 1;
        idle_inputs();
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        // Legal and illegal accesses presented while reset is held must stay masked.
        @(posedge clk_i); #1;
        mem_read_m_i = 1; funct3_m_i = 3'b010; addr_m_i = 32'h40;
        @(posedge clk_i); #1;
        funct3_m_i = 3'b011;
        @(posedge clk_i); #1;
        idle_inputs();
        rst_i = 0;

        do_access(1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_access(0, 1, 3'b000, 32'h203, 0, 32'h80FF_0000, 0, 0, 0);
        do_access(0, 1, 3'b100, 32'h203, 0, 32'h80FF_0000, 0, 0, 0);
        do_access(1, 0, 3'b001, 32'h102, 32'h0000_1234, 0, 3, 0, 0);
        do_access(0, 1, 3'b010, 32'h101, 0, 0, 0, 0, 0);
        reset_mid(0);
        reset_mid(1);
        do_access(0, 1, 3'b010, 32'h400, 0, 32'h1357_2468, 2, 1, 1);
        do_access(1, 1, 3'b000, 32'h007, 32'h0000_00AB, 0, 0, 0, 0);
        do_access(1, 0, 3'b100, 32'h010, 32'h55, 0, 0, 0, 0);
        do_access(0, 1, 3'b101, 32'h012, 0, 32'h8001_7FFF, 1, 0, 0);
        do_access(0, 1, 3'b001, 32'h012, 0, 32'h8001_7FFF, 0, 2, 0);

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom % 2);
            rd = we ? 1'($urandom % 2) : 1'b1;
            do_access(we, rd, 3'($urandom % 8), $urandom, $urandom, $urandom,
                      int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2));
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
